blkrecon: RTL and testbench

//  Motion-compensation reconstructor: decoder-side inverse of blkcompare. Per block, fetches

---
 rtl/mpeg2_pkg.sv | 11 +
 rtl/blkrecon_fifo.sv | 39 +++
 rtl/blkrecon.sv | 115 +++++++++++
 tb/tb_blkrecon.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_pkg.sv
// mpeg2_pkg: shared component codes, block geometry and reconstructor state type
package mpeg2_pkg;
  localparam logic [1:0] CC_Y = 2'd0;
  localparam logic [1:0] CC_U = 2'd1;
  localparam logic [1:0] CC_V = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  // Chroma blocks are 8x8; luma and the reserved code 3 are 16x16
  function automatic logic [4:0] blk_dim(input logic [1:0] cc);
    return (cc == CC_U || cc == CC_V) ? 5'd8 : 5'd16;
  endfunction
endpackage

// File: rtl/blkrecon_fifo.sv
// blkrecon_fifo: residual FIFO; an empty FIFO passes the incoming word straight through
module blkrecon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          empty, byp, wr, rd;
  assign empty  = cnt_q == '0;
  assign byp    = empty & push_i & pop_i;
  assign wr     = push_i & ~byp;
  assign rd     = pop_i & ~empty;
  assign dout_o = empty ? din_i : mem_q[rp_q];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wr ? inc(wp_q) : wp_q;
      rp_q  <= rd ? inc(rp_q) : rp_q;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/blkrecon.sv
// blkrecon: motion-compensated block reconstruction, pixel = clamp(ref + residual, 0, 255)
module blkrecon
  import mpeg2_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int RES_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       cc,
  output logic             rdy,
  output logic [3:0]       rx,
  output logic [3:0]       ry,
  input  logic [RES_W-1:0] rq,
  output logic [3:0]       mx,
  output logic [3:0]       my,
  output logic             mreq,
  input  logic             m_wait,
  input  logic             m_valid,
  input  logic [7:0]       mq,
  output logic [3:0]       wx,
  output logic [3:0]       wy,
  output logic [7:0]       wdata,
  output logic             wren,
  output logic [8:0]       sat_cnt,
  output logic             err
);
  localparam int OW = $clog2(MAX_OUT + 1);
  state_t               st_q, st_d;
  logic                 small_q, iss_q, wren_q, err_q;
  logic [7:0]           icnt_q, wdata_q;
  logic [8:0]           acnt_q, sat_q;
  logic [3:0]           wx_q, wy_q;
  logic [OW-1:0]        out_q;
  logic                 start, iss, acc, last_iss, last_wr, unf, ovf;
  logic [RES_W-1:0]     res;
  logic signed [RES_W:0] sum;
  blkrecon_fifo #(.DEPTH(MAX_OUT), .W(RES_W)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push_i (iss_q),
    .din_i  (rq),
    .pop_i  (acc),
    .dout_o (res)
  );
  assign start    = rdy & en;
  assign acc      = m_valid & (out_q != '0);
  assign last_iss = iss & (icnt_q == (small_q ? 8'd63 : 8'd255));
  assign last_wr  = wren_q & (acnt_q == (small_q ? 9'd64 : 9'd256));
  assign sum      = $signed({{(RES_W - 7){1'b0}}, mq}) + $signed({res[RES_W-1], res});
  assign unf      = sum[RES_W];
  assign ovf      = ~unf & (|sum[RES_W-1:8]);
  assign rx       = small_q ? {1'b0, icnt_q[2:0]} : icnt_q[3:0];
  assign ry       = small_q ? {1'b0, icnt_q[5:3]} : icnt_q[7:4];
  assign mx       = rx;
  assign my       = ry;
  assign mreq     = iss;
  assign wx       = wx_q;
  assign wy       = wy_q;
  assign wdata    = wdata_q;
  assign wren     = wren_q;
  assign sat_cnt  = sat_q;
  assign err      = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st_q <= ST_IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  st_d = en ? ST_RUN : ST_IDLE;
      ST_RUN:   st_d = last_iss ? ST_DRAIN : ST_RUN;
      ST_DRAIN: st_d = last_wr ? ST_IDLE : ST_DRAIN;
      default:  st_d = ST_IDLE;
    endcase
  end
  always_comb begin
    rdy = st_q == ST_IDLE;
    iss = (st_q == ST_RUN) & ~m_wait & (out_q < OW'(MAX_OUT));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      small_q <= 1'b0;
      iss_q   <= 1'b0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
      icnt_q  <= '0;
      acnt_q  <= '0;
      sat_q   <= '0;
      wdata_q <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      out_q   <= '0;
    end else begin
      iss_q  <= iss;
      wren_q <= acc;
      out_q  <= out_q + OW'(iss) - OW'(acc);
      err_q  <= ~start & (err_q | (m_valid & (out_q == '0)));
      if (start) begin
        small_q <= blk_dim(cc) == 5'd8;
        icnt_q  <= '0;
        acnt_q  <= '0;
        sat_q   <= '0;
      end else begin
        if (iss) icnt_q <= icnt_q + 8'd1;
        if (acc) acnt_q <= acnt_q + 9'd1;
        if (acc) sat_q <= sat_q + 9'(unf | ovf);
      end
      if (acc) begin
        wdata_q <= unf ? 8'd0 : ovf ? 8'd255 : sum[7:0];
        wx_q    <= small_q ? {1'b0, acnt_q[2:0]} : acnt_q[3:0];
        wy_q    <= small_q ? {1'b0, acnt_q[5:3]} : acnt_q[7:4];
      end
    end
endmodule

// File: tb/tb_blkrecon.sv
// tb_blkrecon: randomized reference-memory/residual model checking blkrecon writes
module tb_blkrecon;
  localparam int MAX_OUT = 4;
  localparam int RES_W   = 16;
  logic             clk = 1'b0, reset_n = 1'b1, en = 1'b0;
  logic [1:0]       cc = 2'd0;
  logic             rdy, mreq, wren, err;
  logic             m_wait = 1'b0, m_valid = 1'b0;
  logic [3:0]       rx, ry, mx, my, wx, wy;
  logic [RES_W-1:0] rq = '0;
  logic [7:0]       mq = '0, wdata;
  logic [8:0]       sat_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  blkrecon #(.MAX_OUT(MAX_OUT), .RES_W(RES_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cc(cc), .rdy(rdy),
    .rx(rx), .ry(ry), .rq(rq), .mx(mx), .my(my), .mreq(mreq),
    .m_wait(m_wait), .m_valid(m_valid), .mq(mq), .wx(wx), .wy(wy),
    .wdata(wdata), .wren(wren), .sat_cnt(sat_cnt), .err(err)
  );
  typedef struct {int addr; int due;} req_t;
  req_t pend[$];
  int refm[256], resm[256], expv[256];
  int cyc = 0, dim = 16, nblk = 256, nissued = 0, nret = 0, nwr = 0, esat = 0;
  int last_due = 0, maxlat = 1, wait_pct = 0, prev_addr = 0;
  bit prev_mreq = 0, prev_acc = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic fillc(input int r, input int s);
    for (int i = 0; i < 256; i++) begin
      refm[i] = r;
      resm[i] = s;
    end
  endtask
  task automatic fillr();
    for (int i = 0; i < 256; i++) begin
      refm[i] = $urandom_range(0, 255);
      resm[i] = $urandom_range(0, 600) - 300;
    end
  endtask
  task automatic step(input bit do_en, input bit spur);
    bit genuine;
    req_t r;
    int lat, d;
    genuine = 0;
    @(posedge clk);
    #1;
    cyc++;
    en = do_en;
    m_wait = $urandom_range(0, 99) < wait_pct;
    rq = prev_mreq ? RES_W'(resm[prev_addr]) : RES_W'($urandom);
    m_valid = 1'b0;
    mq = 8'($urandom);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      m_valid = 1'b1;
      mq = 8'(refm[r.addr]);
      genuine = 1;
      nret++;
    end else if (spur) m_valid = 1'b1;
    @(negedge clk);
    chk("wren", wren, prev_acc);
    if (wren && nwr < nblk) begin
      chk("wx", wx, nwr % dim);
      chk("wy", wy, nwr / dim);
      chk("wdata", wdata, expv[nwr]);
      nwr++;
    end
    prev_mreq = mreq;
    if (mreq) begin
      chk("mreq_wait", m_wait, 0);
      chk("issue_cnt", nissued < nblk, 1);
      chk("mx", mx, nissued % dim);
      chk("my", my, nissued / dim);
      chk("rx", rx, nissued % dim);
      chk("ry", ry, nissued / dim);
      prev_addr = nissued % 256;
      nissued++;
      chk("outstanding", (nissued - (nret - int'(genuine))) <= MAX_OUT, 1);
      lat = $urandom_range(1, maxlat);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{prev_addr, d});
    end
    prev_acc = genuine;
  endtask
  task automatic reset_mid();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    en = 1'b0;
    m_valid = 1'b0;
    m_wait = 1'b0;
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_mreq", mreq, 0);
    chk("rst_wren", wren, 0);
    chk("rst_err", err, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_addr", {mx, my, wx, wy}, 0);
    chk("rst_wdata", wdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pend.delete();
    prev_acc = 0;
    prev_mreq = 0;
  endtask
  task automatic run_block(input logic [1:0] c, input int ml, input int wp, input int noise_at, input int abort);
    int s;
    dim = (c == 2'd1 || c == 2'd2) ? 8 : 16;
    nblk = dim * dim;
    esat = 0;
    for (int i = 0; i < nblk; i++) begin
      s = refm[i] + resm[i];
      expv[i] = s < 0 ? 0 : s > 255 ? 255 : s;
      if (s < 0 || s > 255) esat++;
    end
    maxlat = ml;
    wait_pct = wp;
    nissued = 0;
    nret = 0;
    nwr = 0;
    last_due = cyc;
    pend.delete();
    chk("rdy_idle", rdy, 1);
    cc = c;
    step(1, 0);
    for (int t = 0; nwr < nblk && t < 5000; t++) begin
      if (abort > 0 && t == abort) begin
        reset_mid();
        return;
      end
      step(t == noise_at, 0);
    end
    chk("writes", nwr, nblk);
    chk("rdy_last", rdy, 0);
    wait_pct = 0;
    step(0, 0);
    chk("rdy_done", rdy, 1);
    chk("sat_cnt", sat_cnt, esat);
    chk("err", err, 0);
  endtask
  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("init_rdy", rdy, 1);
    chk("init_mreq", mreq, 0);
    chk("init_wren", wren, 0);
    chk("init_err", err, 0);
    chk("init_sat", sat_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    fillc(128, 5);
    run_block(2'd0, 1, 0, -1, 0);
    fillc(250, 20);
    run_block(2'd1, 1, 0, -1, 0);
    fillc(3, -9);
    run_block(2'd2, 1, 0, -1, 0);
    step(0, 1);
    step(0, 0);
    chk("err_set", err, 1);
    chk("sat_hold", sat_cnt, 64);
    fillr();
    run_block(2'd1, 3, 20, -1, 0);
    fillr();
    run_block(2'd0, 4, 30, -1, 50);
    fillr();
    run_block(2'd0, 1, 0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      fillr();
      run_block(2'($urandom_range(0, 3)), 6, 40, -1, 0);
    end
    fillr();
    run_block(2'd1, 4, 20, 20, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
